// File: rtl/io_pkg.sv
// Shared constants and types for the IO-space responder: register map,
// status bit layout and the per-button debouncer state encoding.
package io_pkg;

  localparam logic [1:0] IO_STATUS = 2'b00;
  localparam logic [1:0] IO_SWLO   = 2'b01;
  localparam logic [1:0] IO_SWHI   = 2'b10;
  localparam logic [1:0] IO_LED    = 2'b11;

  localparam int ST_LREADY  = 0;
  localparam int ST_SREADY  = 1;
  localparam int ST_OVERRUN = 2;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic {
    DB_LOW  = 1'b0,
    DB_HIGH = 1'b1
  } db_state_t;

  typedef struct packed {
    logic overrun;
    logic sready;
    logic lready;
  } status_t;

  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w = '0;
    w[ST_LREADY]  = s.lready;
    w[ST_SREADY]  = s.sready;
    w[ST_OVERRUN] = s.overrun;
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-flop synchronizer, stable-count debouncer and a
// single-cycle pulse on the debounced rising edge.
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  db_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          differ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg  <= 2'b00;
      state_reg <= DB_LOW;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Any cycle of agreement restarts the count; the toggle resets it too.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    differ     = sync_reg[1] != (state_reg == DB_HIGH);
    if (differ) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = (state_reg == DB_HIGH) ? DB_LOW : DB_HIGH;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Rise fires on the toggling edge itself so the flag lands with the level.
  always_comb begin
    level = (state_reg == DB_HIGH);
    rise  = (state_reg == DB_LOW) && (state_next == DB_HIGH);
  end

endmodule

// File: rtl/io_port_responder.sv
// IO-space peripheral: LED register, captured switch snapshot and a status
// register whose ready flags are raised by debounced button presses.
module io_port_responder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pRead,
  input  logic        pWrite,
  input  logic [1:0]  addr,
  input  logic [11:0] writeData,
  output logic [31:0] readData,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] switch,
  output logic [11:0] led
);

  logic [1:0]  btn_raw;
  logic [1:0]  btn_level;
  logic [1:0]  btn_rise;
  logic        unused_levels;

  logic [15:0] sw_sync1_reg, sw_sync2_reg;
  logic [15:0] sw_latch_reg, sw_latch_next;
  logic [11:0] led_reg, led_next;
  status_t     status_reg, status_next;
  logic        wr_led, rd_swhi;

  assign btn_raw = {btnR, btnL};

  // Index 0 is the LED-ready button, index 1 the switch-capture button.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_raw[gi]),
        .level(btn_level[gi]),
        .rise (btn_rise[gi])
      );
    end
  endgenerate

  // Debounced levels are not mapped into the register file.
  assign unused_levels = ^btn_level;

  assign wr_led  = pWrite && (addr == IO_LED);
  assign rd_swhi = pRead && (addr == IO_SWHI);

  // Set beats clear, except a capture racing an SWHI read leaves no overrun.
  always_comb begin
    led_next            = wr_led ? writeData : led_reg;
    sw_latch_next       = btn_rise[1] ? sw_sync2_reg : sw_latch_reg;
    status_next.lready  = btn_rise[0] | (status_reg.lready & ~wr_led);
    status_next.sready  = btn_rise[1] | (status_reg.sready & ~rd_swhi);
    status_next.overrun = ~rd_swhi &
                          (status_reg.overrun | (btn_rise[1] & status_reg.sready));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
      sw_latch_reg <= '0;
      led_reg      <= '0;
      status_reg   <= '0;
    end else begin
      sw_sync1_reg <= switch;
      sw_sync2_reg <= sw_sync1_reg;
      sw_latch_reg <= sw_latch_next;
      led_reg      <= led_next;
      status_reg   <= status_next;
    end
  end

  always_comb begin
    readData = '0;
    if (pRead) begin
      case (addr)
        IO_STATUS: readData = status_word(status_reg);
        IO_SWLO:   readData = {24'b0, sw_latch_reg[7:0]};
        IO_SWHI:   readData = {24'b0, sw_latch_reg[15:8]};
        default:   readData = {20'b0, led_reg};
      endcase
    end
  end

  assign led = led_reg;

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Memory-mapped peripheral that answers the processor's IO-space accesses: `pRead`/`pWrite` strobes plus a two-bit word select. Holds a 12-bit LED output register and a latched 16-bit switch snapshot. Exposes a status register whose ready flags are raised by debounced `btnL`/`btnR` presses. Sits behind the data-memory decoder, which drives `pRead`, `pWrite`, `addr[3:2]` and `writeData[11:0]`, and consumes `readData` when `addr[7]` is set.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles a button must hold before its debounced level changes; must be ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pRead`  in  1  IO read strobe; level, one cycle per access.
- `pWrite`  in  1  IO write strobe; one cycle per store.
- `addr`  in  2  word select (bus `addr[3:2]`).
- `writeData`  in  12  store data.
- `readData`  out  32  read data; combinational from `addr` and register state.
- `btnL`  in  1  raw asynchronous push-button (LED-ready event).
- `btnR`  in  1  raw asynchronous push-button (switch-capture event).
- `switch`  in  16  raw asynchronous slide switches.
- `led`  out  12  LED register.

## Operation
- **Register map** (by `addr`):
  - 00 STATUS (read-only): bit0 `lready`, bit1 `sready`, bit2 `overrun`, others 0.
  - 01 SWLO: `{24'b0, swLatch[7:0]}`.
  - 10 SWHI: `{24'b0, swLatch[15:8]}`.
  - 11 LED: `{20'b0, led}`.
- `readData` is 0 whenever `pRead` = 0.
- **Writes:** `pWrite` with `addr` 11 loads `led <= writeData` and clears `lready`. Writes to 00/01/10 are ignored and change no state.
- **Read side effects:** a clock edge with `pRead` and `addr` 10 clears `sready` and `overrun`. Reads of 00, 01 and 11 have no side effects.
- **Button events:** each button passes through a 2-flop synchronizer and a debouncer. An event is one cycle long, on the debounced rising edge only; releases generate nothing.
  - `btnL` event sets `lready`.
  - `btnR` event samples `switch` (through its own 2-flop synchronizer) into `swLatch` and sets `sready`. If `sready` was already 1, it also sets `overrun`.
- **Simultaneous events:** a set and a clear of the same flag on one edge resolve to set; no event is lost. A `btnR` event coinciding with an SWHI read reloads `swLatch`, leaves `sready` = 1, and sets `overrun` = 0. Both buttons may fire on the same edge independently.
- **Debouncer state machine, per button:**
  - State: registered level `db` and counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - While the synchronized level equals `db`: `cnt <= 0`.
  - While it differs: `cnt` increments. On the edge where `cnt == DEBOUNCE_CYCLES-1` and it still differs, `db` toggles and `cnt <= 0`.
  - Any cycle of agreement restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
  - `cnt` never wraps.

## Timing
- **Reset:** while `reset` = 0, everything clears asynchronously: `led` = 0, `swLatch` = 0, all flags 0, all synchronizers/`db`/`cnt` 0, `readData` = 0.
  - Release is synchronous to the next edge, so the first updates happen one edge after deassertion.
  - Reset mid-debounce discards the partial count. A button held through reset produces one event `DEBOUNCE_CYCLES+2` edges after release.
- **Read latency:** zero cycles; `readData` is valid in the same cycle as `pRead`.
- **Write/clear latency:** register updates become visible on the edge that samples the strobe.
- **Press-to-flag latency:** a button high and stable before edge e0 sets its flag at edge e0+1+`DEBOUNCE_CYCLES`. The flag is readable in the following cycle.
- **Captured switch value:** the value present at the inputs 2 edges before the event edge.

## Structure
- Package `io_pkg`:
  - address constants `IO_STATUS`=2'b00, `IO_SWLO`=2'b01, `IO_SWHI`=2'b10, `IO_LED`=2'b11
  - status bit indices `ST_LREADY`=0, `ST_SREADY`=1, `ST_OVERRUN`=2
  - `DEBOUNCE_DEFAULT`=1_000_000
- Sub-module `btn_debounce`:
  - contains the synchronizer, debouncer and rise-event pulse
  - parameter `DEBOUNCE_CYCLES`
  - ports `clk`, `reset`, `btn`, `level`, `rise`
  - instantiated twice
- Switch synchronizer, flags, `swLatch` and `led` live in the top.

## Test plan
Bench parameter: `DEBOUNCE_CYCLES`=4.
1. **Reset:** assert `reset`=0 mid-run with `led`=12'hABC and flags set → all outputs and flags read 0 immediately; after release, STATUS reads 0 and `led` = 0.
2. **LED path:** press `btnL`, hold 10 cycles → STATUS bit0 = 1 exactly 5 edges after the press is first sampled. `pWrite` `addr`=11 `writeData`=12'h5A5 → `led`=12'h5A5 and STATUS bit0 = 0 on that edge.
3. **Switch capture:** `switch`=16'hBEEF, press `btnR` → STATUS = 3'b010, SWLO=8'hEF, SWHI=8'hBE. The SWHI read clears STATUS to 0.
4. **Glitch rejection:** `btnR` pulses of 1, 2 and 3 cycles separated by lows → no event; STATUS stays 0 and `swLatch` is unchanged.
5. **Overrun:** two `btnR` presses without reading, `switch` 16'h1111 then 16'h2222 → STATUS = 3'b110, SWLO=8'h22. An SWHI read clears bits 1–2.
6. **Collision:** a `btnR` event on the same edge as an SWHI read, and a `btnL` event on the same edge as a LED write → `sready`=1, `overrun`=0, `lready`=1, and `led` updated.
